// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: receive-side checker for a VGA stream (pixel recovery, sync lock, timing errors)
//
// Ports:
//   vga_clk       in   pixel clock (only clock)
//   sys_rst_n     in   asynchronous active-low reset
//   vga_hs/vga_vs in   horizontal / vertical sync, asserted level SYNC_POL
//   vga_rgb       in   12-bit pixel {R4,G4,B4}
//   pixel_x/y     out  recovered active-area coordinate (0 outside the active area)
//   pixel_valid   out  active-area pixel while locked
//   rgb_out       out  vga_rgb aligned to pixel_x/pixel_y (0 outside the active area)
//   locked        out  sync-lock state machine is in LOCKED
//   line_err      out  1-cycle pulse: bad hs period or hs pulse width
//   frame_err     out  1-cycle pulse: bad line count or vs pulse width
//   frame_cnt     out  frames completed while locked (wraps)
//   err_cnt       out  cycles with an error pulse (saturates at 255)
//   frame_sum     out  sum of last locked frame's active pixels (CHECKSUM_EN only, else 0)
//   frame_sum_vld out  1-cycle pulse when frame_sum updates (CHECKSUM_EN only, else 0)
//
// Optional feature: define CHECKSUM_EN to build the per-frame pixel checksum.
module vga_timing_monitor #(
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_ACT       = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_ACT       = 480,
    parameter int V_TOTAL     = 525,
    parameter bit SYNC_POL    = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [11:0] vga_rgb,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_valid,
    output logic [11:0] rgb_out,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt,
    output logic [23:0] frame_sum,
    output logic        frame_sum_vld
);
    typedef enum logic [1:0] {ST_UNLOCKED, ST_TRACK, ST_LOCKED} state_t;

    localparam int          TO_W   = $clog2(2 * H_TOTAL + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(2 * H_TOTAL);
    localparam logic [9:0]  HS_M1  = 10'(H_SYNC - 1);
    localparam logic [9:0]  HT_M1  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  VS_N   = 10'(V_SYNC);
    localparam logic [9:0]  VT_N   = 10'(V_TOTAL);
    localparam logic [9:0]  HA0    = 10'(H_SYNC + H_BACK);
    localparam logic [9:0]  HA1    = 10'(H_SYNC + H_BACK + H_ACT);
    localparam logic [9:0]  VA0    = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  VA1    = 10'(V_SYNC + V_BACK + V_ACT);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

    // [0] first sample, [1] second sample, [2] previous second sample (edge history)
    logic [2:0]      hs_q, vs_q;
    logic [11:0]     rgb1_q, rgb2_q, rgb3_q;
    logic [9:0]      h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, v_inc, v_lines;
    logic [TO_W-1:0] to_q, to_d;
    logic            hs_e, hs_f, vs_e, vs_f, timeout, act;
    logic            h_seen_q, h_seen_d, v_seen_q, v_seen_d;
    logic            h_wok_q, h_wok_d, v_wok_q, v_wok_d;
    logic            line_err_q, line_err_d, frame_err_q, frame_err_d;
    state_t          state_q, state_d;
    logic [3:0]      good_q, good_d;
    logic [9:0]      px_q, px_d, py_q, py_d;
    logic            pv_q, pv_d;
    logic [11:0]     rgbo_q, rgbo_d;
    logic [15:0]     fcnt_q, fcnt_d;
    logic [7:0]      ecnt_q, ecnt_d;

    assign hs_e = (hs_q[1] == SYNC_POL) && (hs_q[2] != SYNC_POL);
    assign hs_f = (hs_q[1] != SYNC_POL) && (hs_q[2] == SYNC_POL);
    assign vs_e = (vs_q[1] == SYNC_POL) && (vs_q[2] != SYNC_POL);
    assign vs_f = (vs_q[1] != SYNC_POL) && (vs_q[2] == SYNC_POL);

    // Timing recovery and error detection. Counter _q values during an edge cycle still
    // describe the previous sample, so h_cnt_q == period-1 at an hs edge.
    always_comb begin
        h_cnt_d     = hs_e ? 10'd0 : (h_cnt_q == 10'h3FF ? h_cnt_q : h_cnt_q + 10'd1);
        v_inc       = (v_cnt_q == 10'h3FF) ? v_cnt_q : v_cnt_q + 10'd1;
        // lines elapsed since the last vs edge, counting an hs edge in this very cycle
        v_lines     = hs_e ? v_inc : v_cnt_q;
        v_cnt_d     = vs_e ? 10'd0 : v_lines;
        to_d        = hs_e ? '0 : (to_q == TO_MAX ? to_q : to_q + TO_W'(1));
        timeout     = !hs_e && (to_q >= TO_MAX - TO_W'(1));
        h_wok_d     = hs_f ? (h_cnt_q == HS_M1) : h_wok_q;
        v_wok_d     = vs_f ? (v_lines == VS_N) : v_wok_q;
        // nothing is checked until one full line/frame has been observed
        h_seen_d    = !timeout && (h_seen_q || hs_e);
        v_seen_d    = !timeout && (v_seen_q || vs_e);
        line_err_d  = hs_e && h_seen_q && (h_cnt_q != HT_M1 || !h_wok_q);
        frame_err_d = vs_e && v_seen_q && (v_lines != VT_N || !v_wok_q);
        fcnt_d      = (vs_e && state_q == ST_LOCKED) ? fcnt_q + 16'd1 : fcnt_q;
        ecnt_d      = ((line_err_d || frame_err_d) && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
    end

    // Sync-lock state machine
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        if (timeout) begin
            state_d = ST_UNLOCKED;
            good_d  = 4'd0;
        end else begin
            case (state_q)
                ST_UNLOCKED: if (vs_e) begin
                    state_d = ST_TRACK;
                    good_d  = 4'd0;
                end
                ST_TRACK: if (line_err_d || frame_err_d) begin
                    good_d = 4'd0;
                end else if (vs_e) begin
                    good_d  = good_q + 4'd1;
                    state_d = (good_q + 4'd1 == LOCK_N) ? ST_LOCKED : ST_TRACK;
                end
                ST_LOCKED: if (line_err_d || frame_err_d) begin
                    state_d = ST_TRACK;
                    good_d  = 4'd0;
                end
                default: begin
                    state_d = ST_UNLOCKED;
                    good_d  = 4'd0;
                end
            endcase
        end
    end

    // Pixel output stage, one register after the counters
    always_comb begin
        act    = (h_cnt_q >= HA0) && (h_cnt_q < HA1) && (v_cnt_q >= VA0) && (v_cnt_q < VA1);
        px_d   = act ? h_cnt_q - HA0 : 10'd0;
        py_d   = act ? v_cnt_q - VA0 : 10'd0;
        pv_d   = act && (state_q == ST_LOCKED);
        rgbo_d = act ? rgb3_q : 12'd0;
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hs_q        <= '0;
            vs_q        <= '0;
            rgb1_q      <= '0;
            rgb2_q      <= '0;
            rgb3_q      <= '0;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            to_q        <= '0;
            h_seen_q    <= 1'b0;
            v_seen_q    <= 1'b0;
            h_wok_q     <= 1'b0;
            v_wok_q     <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            state_q     <= ST_UNLOCKED;
            good_q      <= '0;
            px_q        <= '0;
            py_q        <= '0;
            pv_q        <= 1'b0;
            rgbo_q      <= '0;
            fcnt_q      <= '0;
            ecnt_q      <= '0;
        end else begin
            hs_q        <= {hs_q[1:0], vga_hs};
            vs_q        <= {vs_q[1:0], vga_vs};
            rgb1_q      <= vga_rgb;
            rgb2_q      <= rgb1_q;
            rgb3_q      <= rgb2_q;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            to_q        <= to_d;
            h_seen_q    <= h_seen_d;
            v_seen_q    <= v_seen_d;
            h_wok_q     <= h_wok_d;
            v_wok_q     <= v_wok_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            state_q     <= state_d;
            good_q      <= good_d;
            px_q        <= px_d;
            py_q        <= py_d;
            pv_q        <= pv_d;
            rgbo_q      <= rgbo_d;
            fcnt_q      <= fcnt_d;
            ecnt_q      <= ecnt_d;
        end
    end

`ifdef CHECKSUM_EN
    logic [23:0] sum_q, sum_d, sum_add, fsum_q, fsum_d;
    logic        fvld_q, fvld_d;

    // the running sum restarts at every vs edge; a locked edge publishes the closing frame
    always_comb begin
        sum_add = sum_q + (pv_q ? {12'd0, rgbo_q} : 24'd0);
        sum_d   = vs_e ? 24'd0 : sum_add;
        fvld_d  = vs_e && (state_q == ST_LOCKED);
        fsum_d  = fvld_d ? sum_add : fsum_q;
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sum_q  <= '0;
            fsum_q <= '0;
            fvld_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            fsum_q <= fsum_d;
            fvld_q <= fvld_d;
        end
    end

    assign frame_sum     = fsum_q;
    assign frame_sum_vld = fvld_q;
`else
    assign frame_sum     = 24'd0;
    assign frame_sum_vld = 1'b0;
`endif

    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign pixel_valid = pv_q;
    assign rgb_out     = rgbo_q;
    assign locked      = (state_q == ST_LOCKED);
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;
    assign frame_cnt   = fcnt_q;
    assign err_cnt     = ecnt_q;
endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb_vga_timing_monitor: directed bench for vga_timing_monitor using a reduced raster
module tb_vga_timing_monitor;
    localparam int HS = 4, HB = 3, HA = 8, HT = 20;
    localparam int VS = 2, VB = 2, VA = 4, VT = 10;

    logic        clk = 1'b0, rst_n = 1'b0, hs_pin = 1'b1, vs_pin = 1'b1;
    logic [11:0] rgb_pin = 12'd0;
    logic [9:0]  pixel_x, pixel_y;
    logic        pixel_valid, locked, line_err, frame_err, frame_sum_vld;
    logic [11:0] rgb_out;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
    logic [23:0] frame_sum;

    int n_chk = 0, n_err = 0, mode = 0;
    bit mon_en = 1'b0;
    int le_n = 0, fe_n = 0, vld_n = 0, drop_bad = 0, rgb_bad = 0, blank_bad = 0;
    int val_n = 0, first_xy = -1, last_xy = -1;
    int le0, fe0, vld0;

    vga_timing_monitor #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACT(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_ACT(VA), .V_TOTAL(VT),
        .SYNC_POL(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .vga_clk(clk), .sys_rst_n(rst_n), .vga_hs(hs_pin), .vga_vs(vs_pin), .vga_rgb(rgb_pin),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid), .rgb_out(rgb_out),
        .locked(locked), .line_err(line_err), .frame_err(frame_err), .frame_cnt(frame_cnt),
        .err_cnt(err_cnt), .frame_sum(frame_sum), .frame_sum_vld(frame_sum_vld)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pat(input int m, input int x, input int y);
        logic [3:0] xs, ys;
        xs = x[3:0];
        ys = y[3:0];
        return (m == 0) ? 12'hF00 : (m == 1) ? {xs, ys, ~xs} : 12'hFFF;
    endfunction

    // passive observer: counts pulses and checks every output pixel against the pattern
    always @(negedge clk) begin
        if (line_err) le_n++;
        if (frame_err) fe_n++;
        if (frame_sum_vld) vld_n++;
        if ((line_err || frame_err) && locked) drop_bad++;
        if (pixel_valid) begin
            if (rgb_out !== pat(mode, int'(pixel_x), int'(pixel_y))) rgb_bad++;
            if (mon_en) begin
                if (val_n == 0) first_xy = int'(pixel_x) * 1024 + int'(pixel_y);
                last_xy = int'(pixel_x) * 1024 + int'(pixel_y);
                val_n++;
            end
        end else if (locked && (rgb_out !== 12'd0 || pixel_x !== 10'd0 || pixel_y !== 10'd0)) begin
            blank_bad++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_line(input int ln, input int period, input int nclk);
        for (int hp = 0; hp < period && hp < nclk; hp++) begin
            @(posedge clk);
            #1;
            hs_pin  = (hp < HS) ? 1'b0 : 1'b1;
            vs_pin  = (ln < VS) ? 1'b0 : 1'b1;
            rgb_pin = (hp >= HS + HB && hp < HS + HB + HA && ln >= VS + VB && ln < VS + VB + VA)
                      ? pat(mode, hp - HS - HB, ln - VS - VB) : 12'h5A5;
        end
    endtask

    task automatic drive_frame(input int nlines, input int bad_ln);
        for (int ln = 0; ln < nlines; ln++) drive_line(ln, (ln == bad_ln) ? HT + 1 : HT, 1000);
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pix", {pixel_x, pixel_y, pixel_valid, rgb_out}, 64'd0);
        check("rst_flags", {locked, line_err, frame_err, frame_sum_vld}, 64'd0);
        check("rst_cnt", {frame_cnt, err_cnt, frame_sum}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // nominal frames: lock at the 3rd vs edge, first counted frame at the 4th
        drive_frame(VT, -1);
        drive_frame(VT, -1);
        @(negedge clk);
        check("lock_pre", locked, 1'b0);
        drive_frame(VT, -1);
        @(negedge clk);
        check("lock_3rd", locked, 1'b1);
        check("fcnt_3rd", frame_cnt, 16'd0);
        drive_frame(VT, -1);
        @(negedge clk);
        check("fcnt_4th", frame_cnt, 16'd1);
        check("no_errs", {le_n[15:0], fe_n[15:0], err_cnt}, 40'd0);
        check("solid_rgb", rgb_bad, 0);

        // one long line while locked
        le0 = le_n;
        drive_frame(VT, 3);
        @(negedge clk);
        check("long_line_err", le_n - le0, 1);
        check("long_line_unlock", locked, 1'b0);
        check("err_cnt_1", err_cnt, 8'd1);
        check("drop_same_cycle", drop_bad, 0);
        drive_frame(VT, -1);
        @(negedge clk);
        check("relock_1frame", locked, 1'b0);
        drive_frame(VT, -1);
        @(negedge clk);
        check("relock_2frames", locked, 1'b1);
        check("fcnt_relock", frame_cnt, 16'd2);

        // short frame while locked
        fe0 = fe_n;
        drive_frame(VT, -1);
        drive_frame(VT - 1, -1);
        @(negedge clk);
        check("short_pre", {fe_n - fe0, 31'd0, locked}, {32'd0, 32'd1});
        drive_frame(VT, -1);
        @(negedge clk);
        check("short_frame_err", fe_n - fe0, 1);
        check("err_cnt_2", err_cnt, 8'd2);
        check("short_unlock", locked, 1'b0);
        check("fcnt_exit_edge", frame_cnt, 16'd5);
        check("drop_same_cycle2", drop_bad, 0);

        // gradient frame, fully observed while locked
        mode = 1;
        drive_frame(VT, -1);
        mon_en = 1'b1;
        drive_frame(VT, -1);
        @(negedge clk);
        mon_en = 1'b0;
        check("grad_count", val_n, HA * VA);
        check("grad_first", first_xy, 0);
        check("grad_last", last_xy, (HA - 1) * 1024 + (VA - 1));
        check("grad_rgb", rgb_bad, 0);
        check("blank_zero", blank_bad, 0);

        // loss of hs -> timeout, then reset mid-line
        mode = 0;
        drive_frame(VT, -1);
        @(negedge clk);
        check("pre_timeout_lock", locked, 1'b1);
        hs_pin = 1'b1;
        vs_pin = 1'b1;
        repeat (2 * HT + 10) @(posedge clk);
        @(negedge clk);
        check("timeout_unlock", locked, 1'b0);
        drive_frame(VT, -1);
        drive_line(0, HT, 7);
        @(negedge clk);
        check("pre_rst_cnts", {frame_cnt, err_cnt}, {16'd6, 8'd2});
        #2 rst_n = 1'b0;
        hs_pin = 1'b1;
        vs_pin = 1'b1;
        mode = 2;
        @(negedge clk);
        check("midrst_pix", {pixel_x, pixel_y, pixel_valid, rgb_out}, 64'd0);
        check("midrst_flags", {locked, line_err, frame_err, frame_sum_vld}, 64'd0);
        check("midrst_cnt", {frame_cnt, err_cnt, frame_sum}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // all-ones frame checksum
        vld0 = vld_n;
        drive_frame(VT, -1);
        drive_frame(VT, -1);
        drive_frame(VT, -1);
        drive_frame(VT, -1);
        @(negedge clk);
        check("ones_lock", {frame_cnt, 15'd0, locked}, {16'd1, 16'd1});
`ifdef CHECKSUM_EN
        check("frame_sum", frame_sum, 24'h01FFE0);
        check("frame_sum_vld", vld_n - vld0, 1);
`else
        check("frame_sum_off", frame_sum, 24'd0);
        check("frame_sum_vld_off", vld_n - vld0, 0);
`endif
        check("ones_rgb", rgb_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
